// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package seq_chunk_adder_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   function automatic int unsigned nchunk_of(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   // Chunk index width; a single-chunk configuration still needs a 1-bit index.
   function automatic int unsigned idx_width(input int unsigned width, input int unsigned chunk);
      int unsigned n;
      n = width / chunk;
      return (n > 1) ? 32'($clog2(n)) : 32'd1;
   endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry into the top bit.
module chunk_ripple_adder #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_slice,
   input  logic [CHUNK-1:0] b_slice,
   input  logic             cin,
   output logic [CHUNK-1:0] sum_slice,
   output logic             cout,
   output logic             c_msb_in
);

   logic carry;

   always_comb begin
      carry     = cin;
      c_msb_in  = 1'b0;
      sum_slice = '0;
      for (int i = 0; i < int'(CHUNK); i++) begin
         c_msb_in     = carry;
         sum_slice[i] = a_slice[i] ^ b_slice[i] ^ carry;
         carry        = (a_slice[i] & b_slice[i]) | (carry & (a_slice[i] ^ b_slice[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock with a registered carry, valid/ready on both sides.
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int unsigned NCHUNK = nchunk_of(WIDTH, CHUNK);
   localparam int unsigned IDXW   = idx_width(WIDTH, CHUNK);

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("seq_chunk_adder: CHUNK must be >= 1 and divide WIDTH");
   end

   state_t            state;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry;
   logic [IDXW-1:0]   idx;
   logic [CHUNK-1:0]  a_slice;
   logic [CHUNK-1:0]  b_slice;
   logic [CHUNK-1:0]  sum_slice;
   logic              slice_cout;
   logic              slice_c_msb;
   logic              last;

   assign a_slice = a_q[idx*CHUNK +: CHUNK];
   assign b_slice = b_q[idx*CHUNK +: CHUNK];
   assign last    = (idx == IDXW'(NCHUNK - 1));

   chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
      .a_slice   (a_slice),
      .b_slice   (b_slice),
      .cin       (carry),
      .sum_slice (sum_slice),
      .cout      (slice_cout),
      .c_msb_in  (slice_c_msb)
   );

   // Subtract is folded in at capture: B inverted, carry seeded with 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         overflow  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         carry     <= 1'b0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q      <= a;
                  b_q      <= sub ? ~b : b;
                  carry    <= sub ? 1'b1 : c_in;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               sum[idx*CHUNK +: CHUNK] <= sum_slice;
               carry                   <= slice_cout;
               idx                     <= idx + IDXW'(1);
               if (last) begin
                  c_out     <= slice_cout;
                  overflow  <= slice_c_msb ^ slice_cout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and randomised checks of seq_chunk_adder, including a parameter sweep.
module tb_seq_chunk_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        c_out;
   logic        overflow;

   int passed = 0;
   int total  = 0;
   logic busy_ok;

   always #5 clk = ~clk;

   seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .overflow  (overflow)
   );

   // Sweep instances: (WIDTH, CHUNK) = (16,1) (16,4) (16,16) (8,8)
   localparam int unsigned SW_W[4] = '{16, 16, 16, 8};
   localparam int unsigned SW_C[4] = '{1, 4, 16, 8};

   logic        sw_in_valid[4];
   logic        sw_in_ready[4];
   logic [15:0] sw_a[4];
   logic [15:0] sw_b[4];
   logic        sw_c_in[4];
   logic        sw_sub[4];
   logic        sw_out_valid[4];
   logic        sw_out_ready[4];
   logic [15:0] sw_sum[4];
   logic        sw_c_out[4];
   logic        sw_ovf[4];

   for (genvar g = 0; g < 4; g++) begin : g_sw
      localparam int unsigned W = SW_W[g];
      localparam int unsigned C = SW_C[g];
      logic [W-1:0] sm;
      seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) u (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (sw_in_valid[g]),
         .in_ready  (sw_in_ready[g]),
         .a         (W'(sw_a[g])),
         .b         (W'(sw_b[g])),
         .c_in      (sw_c_in[g]),
         .sub       (sw_sub[g]),
         .out_valid (sw_out_valid[g]),
         .out_ready (sw_out_ready[g]),
         .sum       (sm),
         .c_out     (sw_c_out[g]),
         .overflow  (sw_ovf[g])
      );
      assign sw_sum[g] = 16'(sm);
   end

   // Reference: W-bit two's-complement add/subtract.
   function automatic void model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mci, input logic msub,
                                 output logic [15:0] ms, output logic mco, output logic mov);
      logic [16:0] mask;
      logic [16:0] bb;
      logic [16:0] full;
      mask = (17'd1 << w) - 17'd1;
      bb   = msub ? (~{1'b0, mb} & mask) : ({1'b0, mb} & mask);
      full = ({1'b0, ma} & mask) + bb + 17'(msub ? 1'b1 : mci);
      mco  = full[w];
      ms   = full[15:0] & mask[15:0];
      mov  = (ma[w-1] == bb[w-1]) && (ms[w-1] != ma[w-1]);
   endfunction

   // Drive one operation on the main DUT from a negedge; returns edges from acceptance to out_valid.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic ts, output int lat);
      a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         @(posedge clk); @(negedge clk);
         lat++;
      end
      if (in_ready) busy_ok = 1'b0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sw_in_valid[i] = 1'b0; sw_out_ready[i] = 1'b0; sw_a[i] = '0; sw_b[i] = '0;
         sw_c_in[i] = 1'b0; sw_sub[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else passed++;
      total++; if (c_out !== 1'b0) $display("FAIL reset_c_out got %b want 0", c_out); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
   endtask

   task automatic test_basic_add();
      int lat;
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
      total++; if (lat != 4) $display("FAIL basic_latency got %0d want 4", lat); else passed++;
      total++; if (busy_ok !== 1'b1) $display("FAIL basic_in_ready_busy got in_ready high while busy want low"); else passed++;
      total++; if (sum !== 16'h0100) $display("FAIL basic_sum got %h want 0100", sum); else passed++;
      total++; if (c_out !== 1'b0) $display("FAIL basic_c_out got %b want 0", c_out); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL basic_overflow got %b want 0", overflow); else passed++;
      release_result();
      total++; if (in_ready !== 1'b1) $display("FAIL basic_return_idle got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_vectors(input string name, input logic vsub, input logic [15:0] va[3],
                               input logic [15:0] vb[3], input logic [15:0] vs[3],
                               input logic vc[3], input logic vo[3], input int n);
      int lat;
      for (int i = 0; i < n; i++) begin
         do_op(va[i], vb[i], vsub, vsub, lat);
         total++; if (lat != 4) $display("FAIL %s_%0d_latency got %0d want 4", name, i, lat); else passed++;
         total++; if (sum !== vs[i]) $display("FAIL %s_%0d_sum got %h want %h", name, i, sum, vs[i]); else passed++;
         total++; if (c_out !== vc[i]) $display("FAIL %s_%0d_c_out got %b want %b", name, i, c_out, vc[i]); else passed++;
         total++; if (overflow !== vo[i]) $display("FAIL %s_%0d_overflow got %b want %b", name, i, overflow, vo[i]); else passed++;
         release_result();
      end
   endtask

   task automatic test_corners();
      logic [15:0] va[3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
      logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'h8000};
      logic [15:0] vs[3] = '{16'h0000, 16'h8000, 16'h0000};
      logic        vc[3] = '{1'b1, 1'b0, 1'b1};
      logic        vo[3] = '{1'b0, 1'b1, 1'b1};
      test_vectors("corner", 1'b0, va, vb, vs, vc, vo, 3);
   endtask

   // c_in is driven equal to sub (1) and must be ignored in subtract mode.
   task automatic test_subtract();
      logic [15:0] va[3] = '{16'h0005, 16'h8000, 16'h0000};
      logic [15:0] vb[3] = '{16'h0007, 16'h0001, 16'h0000};
      logic [15:0] vs[3] = '{16'hFFFE, 16'h7FFF, 16'h0000};
      logic        vc[3] = '{1'b0, 1'b1, 1'b1};
      logic        vo[3] = '{1'b0, 1'b1, 1'b0};
      test_vectors("sub", 1'b1, va, vb, vs, vc, vo, 3);
   endtask

   task automatic test_backpressure();
      int lat;
      do_op(16'h0123, 16'h0456, 1'b0, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         total++; if (out_valid !== 1'b1) $display("FAIL bp_%0d_out_valid got %b want 1", i, out_valid); else passed++;
         total++; if (in_ready !== 1'b0) $display("FAIL bp_%0d_in_ready got %b want 0", i, in_ready); else passed++;
         total++; if (sum !== 16'h0579) $display("FAIL bp_%0d_sum got %h want 0579", i, sum); else passed++;
      end
      in_valid = 1'b0;
      release_result();
      total++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", out_valid); else passed++;
      total++; if (sum !== 16'h0579) $display("FAIL bp_no_capture_sum got %h want 0579", sum); else passed++;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic spurious;
      a = 16'h00FF; b = 16'h0F0F; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else passed++;
      total++; if (sum !== 16'h0000) $display("FAIL midrst_sum got %h want 0000", sum); else passed++;
      total++; if (c_out !== 1'b0) $display("FAIL midrst_c_out got %b want 0", c_out); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL midrst_overflow got %b want 0", overflow); else passed++;
      spurious = 1'b0;
      repeat (6) begin
         @(posedge clk); @(negedge clk);
         if (out_valid) spurious = 1'b1;
      end
      total++; if (spurious !== 1'b0) $display("FAIL midrst_no_pulse got out_valid high want low"); else passed++;
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
      total++; if (lat != 4) $display("FAIL midrst_next_latency got %0d want 4", lat); else passed++;
      total++; if (sum !== 16'h2345) $display("FAIL midrst_next_sum got %h want 2345", sum); else passed++;
      release_result();
   endtask

   task automatic test_param_sweep();
      logic [15:0] ra, rb, es, mask;
      logic        rc, rs, ec, eo;
      int          lat, w, nch;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         w    = int'(SW_W[i]);
         nch  = int'(SW_W[i] / SW_C[i]);
         mask = 16'((17'd1 << w) - 17'd1);
         for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom) & mask; rb = 16'($urandom) & mask;
            rc = 1'($urandom); rs = 1'($urandom);
            sw_a[i] = ra; sw_b[i] = rb; sw_c_in[i] = rc; sw_sub[i] = rs; sw_in_valid[i] = 1'b1;
            @(posedge clk); @(negedge clk);
            sw_in_valid[i] = 1'b0;
            lat = 0;
            while (!sw_out_valid[i] && lat < 64) begin
               @(posedge clk); @(negedge clk);
               lat++;
            end
            model(w, ra, rb, rc, rs, es, ec, eo);
            total++;
            if (lat != nch) $display("FAIL sweep%0d_op%0d_latency got %0d want %0d", i, n, lat, nch);
            else passed++;
            total++;
            if ({sw_sum[i], sw_c_out[i], sw_ovf[i]} !== {es, ec, eo})
               $display("FAIL sweep%0d_op%0d a=%h b=%h ci=%b sub=%b got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                        i, n, ra, rb, rc, rs, sw_sum[i], sw_c_out[i], sw_ovf[i], es, ec, eo);
            else passed++;
            sw_out_ready[i] = 1'b1;
            @(posedge clk); @(negedge clk);
            sw_out_ready[i] = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_corners();
      test_subtract();
      test_backpressure();
      test_reset_mid();
      test_param_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
